// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises I-cache and D-cache line transfers onto one physical-memory port.
// Optional feature macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed D-cache priority.
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   i_req_s;
    logic   d_req_s;
    logic   tie_pick_d_s;
    logic   grant_d_r;

    assign i_req_s = i_read;
    assign d_req_s = d_read | d_write;
    assign grant_d = grant_d_r;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_d_next_r;

    assign tie_pick_d_s = rr_d_next_r;

    // Round-robin pointer: after each completed transfer the other requester wins the next tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_d_next_r <= 1'b0;
        end else if ((state_r == S_GRANT_I) && mem_resp) begin
            rr_d_next_r <= 1'b1;
        end else if ((state_r == S_GRANT_D) && mem_resp) begin
            rr_d_next_r <= 1'b0;
        end else begin
            rr_d_next_r <= rr_d_next_r;
        end
    end
`else
    assign tie_pick_d_s = 1'b1;
`endif

    // State register and registered D-grant indicator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            grant_d_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            grant_d_r <= (state_next_s == S_GRANT_D);
        end
    end

    // Next-state selection and forwarding of the granted requester onto the memory port
    always_comb begin
        state_next_s = state_r;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = {ADDR_W{1'b0}};
        mem_wdata    = {LINE_W{1'b0}};
        i_resp       = 1'b0;
        i_rdata      = {LINE_W{1'b0}};
        d_resp       = 1'b0;
        d_rdata      = {LINE_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (d_req_s && i_req_s) begin
                    if (tie_pick_d_s) begin
                        state_next_s = S_GRANT_D;
                    end else begin
                        state_next_s = S_GRANT_I;
                    end
                end else if (d_req_s) begin
                    state_next_s = S_GRANT_D;
                end else if (i_req_s) begin
                    state_next_s = S_GRANT_I;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_GRANT_I: begin
                mem_read    = i_read;
                mem_address = i_address;
                if (mem_resp) begin
                    i_resp       = 1'b1;
                    i_rdata      = mem_rdata;
                    state_next_s = S_IDLE;
                end else if (!i_req_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_GRANT_I;
                end
            end
            S_GRANT_D: begin
                // Read and write together is illegal; the writeback takes precedence
                mem_write   = d_write;
                mem_read    = d_read & ~d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                if (mem_resp) begin
                    d_resp       = 1'b1;
                    d_rdata      = mem_rdata;
                    state_next_s = S_IDLE;
                end else if (!d_req_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_GRANT_D;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level ownership model.
module tb_cache_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_read;
    logic [15:0]  i_address;
    logic         i_resp;
    logic [127:0] i_rdata;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic         d_resp;
    logic [127:0] d_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         grant_d;

    int n_checks = 0;
    int n_pass   = 0;

    cache_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: who owns the port, and who was served last (for round-robin ties)
    initial begin : compare
        int owner;          // 0 none, 1 I-cache, 2 D-cache
        bit last_d;
        logic e_mr, e_mw, e_ir, e_dr, e_gd;
        logic [15:0] e_ma;
        logic [127:0] e_wd, e_id, e_dd;
        owner  = 0;
        last_d = 1'b1;
        forever begin
            @(negedge clk);
            e_mr = 1'b0; e_mw = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_gd = 1'b0;
            e_ma = 16'h0; e_wd = 128'h0; e_id = 128'h0; e_dd = 128'h0;
            if (reset_n) begin
                if (owner == 1) begin
                    e_mr = i_read;
                    e_ma = i_address;
                    if (mem_resp) begin e_ir = 1'b1; e_id = mem_rdata; end
                end else if (owner == 2) begin
                    e_mw = d_write;
                    e_mr = d_read && !d_write;
                    e_ma = d_address;
                    e_wd = d_wdata;
                    if (mem_resp) begin e_dr = 1'b1; e_dd = mem_rdata; end
                end
                e_gd = (owner == 2);
            end
            check("mdl_mem_read",    {127'h0, mem_read},  {127'h0, e_mr});
            check("mdl_mem_write",   {127'h0, mem_write}, {127'h0, e_mw});
            check("mdl_mem_address", {112'h0, mem_address}, {112'h0, e_ma});
            check("mdl_mem_wdata",   mem_wdata, e_wd);
            check("mdl_i_resp",      {127'h0, i_resp}, {127'h0, e_ir});
            check("mdl_i_rdata",     i_rdata, e_id);
            check("mdl_d_resp",      {127'h0, d_resp}, {127'h0, e_dr});
            check("mdl_d_rdata",     d_rdata, e_dd);
            check("mdl_grant_d",     {127'h0, grant_d}, {127'h0, e_gd});
            if (!reset_n) begin
                owner  = 0;
                last_d = 1'b1;
            end else if (owner == 0) begin
                if ((d_read || d_write) && i_read) owner = (RR && last_d) ? 1 : 2;
                else if (d_read || d_write) owner = 2;
                else if (i_read) owner = 1;
            end else if (mem_resp) begin
                last_d = (owner == 2);
                owner  = 0;
            end else if (owner == 1 && !i_read) begin
                owner = 0;
            end else if (owner == 2 && !(d_read || d_write)) begin
                owner = 0;
            end
        end
    end

    bit tie_d [3];
    bit mem_act;
    int mem_cnt;
    bit i_got, d_got;
    int kind;

    initial begin : stim
        if (RR) begin tie_d[0] = 1'b0; tie_d[1] = 1'b1; tie_d[2] = 1'b0; end
        else    begin tie_d[0] = 1'b1; tie_d[1] = 1'b1; tie_d[2] = 1'b1; end
        reset_n = 1'b0; i_read = 1'b0; i_address = 16'h0; d_read = 1'b0; d_write = 1'b0;
        d_address = 16'h0; d_wdata = 128'h0; mem_resp = 1'b0; mem_rdata = 128'h0;
        tick(); tick();
        check("rst_mem_read", {127'h0, mem_read}, 128'h0);
        check("rst_grant_d", {127'h0, grant_d}, 128'h0);
        check("rst_mem_address", {112'h0, mem_address}, 128'h0);
        reset_n = 1'b1;
        tick();

        // I-cache only, memory answers 3 cycles after the strobe
        i_read = 1'b1; i_address = 16'h1230; settle();
        check("ionly_read_N", {127'h0, mem_read}, 128'h0);
        tick(); settle();
        check("ionly_read_N1", {127'h0, mem_read}, 128'h1);
        check("ionly_addr", {112'h0, mem_address}, {112'h0, 16'h1230});
        check("ionly_resp_early", {127'h0, i_resp}, 128'h0);
        tick(); tick(); tick();
        mem_resp = 1'b1; mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; settle();
        check("ionly_i_resp", {127'h0, i_resp}, 128'h1);
        check("ionly_i_rdata", i_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("ionly_d_resp", {127'h0, d_resp}, 128'h0);
        tick(); mem_resp = 1'b0; i_read = 1'b0; settle();
        check("ionly_resp_pulse", {127'h0, i_resp}, 128'h0);
        check("ionly_rdata_zero", i_rdata, 128'h0);

        // D-cache writeback
        d_write = 1'b1; d_address = 16'h4000; d_wdata = {16{8'hA5}};
        tick(); settle();
        check("dwb_mem_write", {127'h0, mem_write}, 128'h1);
        check("dwb_mem_read", {127'h0, mem_read}, 128'h0);
        check("dwb_wdata", mem_wdata, {16{8'hA5}});
        check("dwb_addr", {112'h0, mem_address}, {112'h0, 16'h4000});
        check("dwb_grant_d", {127'h0, grant_d}, 128'h1);
        mem_resp = 1'b1; mem_rdata = 128'h5; settle();
        check("dwb_d_resp", {127'h0, d_resp}, 128'h1);
        check("dwb_i_resp", {127'h0, i_resp}, 128'h0);
        tick(); mem_resp = 1'b0; d_write = 1'b0;

        // Three back-to-back ties
        tick();
        i_read = 1'b1; i_address = 16'h0100; d_read = 1'b1; d_address = 16'h0200;
        mem_rdata = 128'h77;
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            check($sformatf("tie%0d_grant_d", k), {127'h0, grant_d}, {127'h0, tie_d[k]});
            check($sformatf("tie%0d_addr", k), {112'h0, mem_address},
                  {112'h0, (tie_d[k] ? 16'h0200 : 16'h0100)});
            mem_resp = 1'b1; settle();
            check($sformatf("tie%0d_i_resp", k), {127'h0, i_resp}, {127'h0, !tie_d[k]});
            check($sformatf("tie%0d_d_resp", k), {127'h0, d_resp}, {127'h0, tie_d[k]});
            tick(); mem_resp = 1'b0; settle();
            check($sformatf("tie%0d_bubble", k), {127'h0, mem_read}, 128'h0);
        end
        i_read = 1'b0; d_read = 1'b0;

        // Spurious mem_resp while idle
        tick(); mem_resp = 1'b1; settle();
        check("spur_i_resp", {127'h0, i_resp}, 128'h0);
        check("spur_d_resp", {127'h0, d_resp}, 128'h0);
        check("spur_d_rdata", d_rdata, 128'h0);
        tick(); mem_resp = 1'b0; i_read = 1'b1; i_address = 16'h0ABC; settle();
        check("spur_still_idle", {127'h0, mem_read}, 128'h0);
        tick(); settle();
        check("spur_next_read", {127'h0, mem_read}, 128'h1);
        mem_resp = 1'b1; settle();
        check("spur_next_i_resp", {127'h0, i_resp}, 128'h1);
        tick(); mem_resp = 1'b0; i_read = 1'b0;

        // Reset in the middle of a D grant
        tick(); d_read = 1'b1; d_address = 16'h4440;
        tick(); settle();
        check("rmid_grant_d", {127'h0, grant_d}, 128'h1);
        check("rmid_mem_read", {127'h0, mem_read}, 128'h1);
        reset_n = 1'b0; mem_resp = 1'b1; settle();
        check("rmid_mem_read_off", {127'h0, mem_read}, 128'h0);
        check("rmid_addr_off", {112'h0, mem_address}, 128'h0);
        check("rmid_d_resp", {127'h0, d_resp}, 128'h0);
        check("rmid_grant_off", {127'h0, grant_d}, 128'h0);
        tick(); d_read = 1'b0; mem_resp = 1'b0;
        tick(); reset_n = 1'b1;
        tick(); tick(); settle();
        check("rmid_idle_after", {127'h0, mem_read}, 128'h0);
        check("rmid_grant_after", {127'h0, grant_d}, 128'h0);

        // Randomized traffic; per-cycle checking is done by the model process
        mem_act = 1'b0; mem_cnt = 0; i_got = 1'b0; d_got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            mem_rdata = rand128();
            if (mem_read || mem_write) begin
                if (!mem_act) begin mem_act = 1'b1; mem_cnt = $urandom_range(0, 3); end
                if (mem_cnt == 0) begin mem_resp = 1'b1; mem_act = 1'b0; end
                else begin mem_cnt--; mem_resp = 1'b0; end
            end else begin
                mem_act  = 1'b0;
                mem_resp = ($urandom_range(0, 15) == 0);
            end
            if (i_got || (!i_read && $urandom_range(0, 2) == 0)) begin
                i_read = ($urandom_range(0, 1) == 1);
                i_address = 16'($urandom);
            end else if (i_read && !mem_resp && $urandom_range(0, 49) == 0) begin
                i_read = 1'b0;
            end
            if (d_got || (!d_read && !d_write && $urandom_range(0, 2) == 0)) begin
                kind = $urandom_range(0, 11);
                d_read  = (kind == 0) || (kind >= 6 && kind < 10);
                d_write = (kind >= 0 && kind < 6);
                d_address = 16'($urandom);
                d_wdata = rand128();
            end else if ((d_read || d_write) && !mem_resp && $urandom_range(0, 49) == 0) begin
                d_read = 1'b0; d_write = 1'b0;
            end
            settle();
            i_got = i_resp;
            d_got = d_resp;
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
